trs80_uart_core: RTL and testbench

TR1602-compatible asynchronous UART core. It sits directly below the TRS-80 RS-232 port decoder, which supplies the x16 bit-rate enables, host data and strobes, and reads back the status flags. It provides a transmitter with a holding register and shift register, and a receiver with false-start rejection. Frame format is configurable: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits.

---
 rtl/trs80_uart_core.sv | 235 +++++++++++++++++++++++
 tb/tb_trs80_uart_core.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trs80_uart_core.sv
// TR1602-compatible UART core: buffered transmitter and false-start-rejecting receiver,
// 5-8 data bits, optional odd/even parity, 1 or 2 stop bits, x OVERSAMPLE bit-rate enables.
module trs80_uart_core #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_clk_en,
  input  logic       tx_clk_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       thrl,
  input  logic       crl,
  input  logic       pi,
  input  logic       sbs,
  input  logic [1:0] wls,
  input  logic       epe,
  input  logic       drr_n,
  output logic       pe,
  output logic       fe,
  output logic       oe,
  output logic       thre,
  output logic       tre,
  output logic       dr,
  input  logic       rx,
  output logic       tx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK} rx_state_t;

  function automatic logic [7:0] word_mask(input logic [1:0] w);
    return 8'hFF >> (2'd3 - w);
  endfunction

  // Control register
  logic       c_pi, c_sbs, c_epe;
  logic [1:0] c_wls;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_pi  <= 1'b1;
      c_sbs <= 1'b0;
      c_wls <= 2'b11;
      c_epe <= 1'b0;
    end else if (crl) begin
      c_pi  <= pi;
      c_sbs <= sbs;
      c_wls <= wls;
      c_epe <= epe;
    end
  end

  // Transmitter
  tx_state_t   tst;
  logic [7:0]  thr, tsr;
  logic [CW-1:0] tcnt;
  logic [2:0]  tbit;
  logic        t_pi, t_sbs, t_par, t_stop2;
  logic [1:0]  t_wls;
  logic        t_bit_end, stop_done, tx_load;

  assign t_bit_end = tx_clk_en && (tcnt == LAST);
  assign stop_done = (tst == T_STOP) && t_bit_end && (!t_sbs || t_stop2);
  // Load from IDLE, or straight out of the final stop bit for back-to-back frames
  assign tx_load   = !thre && (((tst == T_IDLE) && tx_clk_en) || stop_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      tst     <= T_IDLE;
      tx      <= 1'b1;
      thre    <= 1'b1;
      tre     <= 1'b1;
      thr     <= '0;
      tsr     <= '0;
      tcnt    <= '0;
      tbit    <= '0;
      t_pi    <= 1'b1;
      t_sbs   <= 1'b0;
      t_wls   <= 2'b11;
      t_par   <= 1'b0;
      t_stop2 <= 1'b0;
    end else begin
      if (tx_load) begin
        tst     <= T_START;
        tx      <= 1'b0;
        tsr     <= thr;
        thre    <= 1'b1;
        tre     <= 1'b0;
        tcnt    <= '0;
        tbit    <= '0;
        t_stop2 <= 1'b0;
        t_pi    <= c_pi;
        t_sbs   <= c_sbs;
        t_wls   <= c_wls;
        t_par   <= (^(thr & word_mask(c_wls))) ^ ~c_epe;
      end else if (stop_done) begin
        tst  <= T_IDLE;
        tx   <= 1'b1;
        tre  <= 1'b1;
        tcnt <= '0;
      end else if (tx_clk_en && tst != T_IDLE) begin
        if (t_bit_end) begin
          tcnt <= '0;
          case (tst)
            T_START: begin
              tst <= T_DATA;
              tx  <= tsr[0];
            end
            T_DATA: begin
              if (tbit == {1'b1, t_wls}) begin
                tst <= t_pi ? T_STOP : T_PAR;
                tx  <= t_pi ? 1'b1 : t_par;
              end else begin
                tbit <= tbit + 1'b1;
                tsr  <= {1'b0, tsr[7:1]};
                tx   <= tsr[1];
              end
            end
            T_PAR: begin
              tst <= T_STOP;
              tx  <= 1'b1;
            end
            T_STOP:  t_stop2 <= 1'b1;
            default: tst <= T_IDLE;
          endcase
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
      // Host write wins over the internal load so a coincident write is not lost
      if (thrl) begin
        thr  <= din;
        thre <= 1'b0;
      end
    end
  end

  // Receiver
  rx_state_t   rst;
  logic        rx_m, rx_s;
  logic [7:0]  rsr, rbr;
  logic [CW-1:0] rcnt;
  logic [2:0]  rbit;
  logic        r_pi, r_epe, r_acc, r_perr;
  logic [1:0]  r_wls;

  assign dout = rbr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rst    <= R_IDLE;
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rsr    <= '0;
      rbr    <= '0;
      rcnt   <= '0;
      rbit   <= '0;
      r_pi   <= 1'b1;
      r_epe  <= 1'b0;
      r_wls  <= 2'b11;
      r_acc  <= 1'b0;
      r_perr <= 1'b0;
      dr     <= 1'b0;
      pe     <= 1'b0;
      fe     <= 1'b0;
      oe     <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (!drr_n) dr <= 1'b0;
      if (rx_clk_en) begin
        case (rst)
          R_IDLE: begin
            if (!rx_s) begin
              rst   <= R_START;
              rcnt  <= '0;
              r_pi  <= c_pi;
              r_epe <= c_epe;
              r_wls <= c_wls;
            end
          end
          R_START: begin
            if (rcnt == HALF) begin
              rcnt <= '0;
              if (rx_s) begin
                rst <= R_IDLE;
              end else begin
                rst    <= R_DATA;
                rbit   <= '0;
                rsr    <= '0;
                r_acc  <= 1'b0;
                r_perr <= 1'b0;
              end
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          R_BREAK: if (rx_s) rst <= R_IDLE;
          default: begin
            if (rcnt != LAST) begin
              rcnt <= rcnt + 1'b1;
            end else begin
              rcnt <= '0;
              case (rst)
                R_DATA: begin
                  rsr   <= {rx_s, rsr[7:1]};
                  r_acc <= r_acc ^ rx_s;
                  rbit  <= rbit + 1'b1;
                  if (rbit == {1'b1, r_wls}) rst <= r_pi ? R_STOP : R_PAR;
                end
                R_PAR: begin
                  r_perr <= rx_s != (r_acc ^ ~r_epe);
                  rst    <= R_STOP;
                end
                default: begin
                  // Data entered at bit 7 and shifted down; right-justify by word length
                  rbr <= rsr >> (2'd3 - r_wls);
                  pe  <= !r_pi && r_perr;
                  fe  <= !rx_s;
                  oe  <= dr;
                  dr  <= 1'b1;
                  rst <= rx_s ? R_IDLE : R_BREAK;
                end
              endcase
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_trs80_uart_core.sv
// Scoreboard bench for trs80_uart_core: frame-level reference model, decoupled tx/rx monitors.
module tb_trs80_uart_core;
  localparam int BIT = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic       clk = 1'b0, reset = 1'b1;
  logic       rx_clk_en, tx_clk_en;
  logic [7:0] din = '0, dout;
  logic       thrl = 0, crl = 0, pi = 1, sbs = 0, epe = 0, drr_n = 1;
  logic [1:0] wls = 2'b11;
  logic       pe, fe, oe, thre, tre, dr, rx, tx;
  logic       rx_drv = 1'b1, loop = 1'b0;
  logic [1:0] tk = '0;

  int checks = 0, errors = 0;
  bit allow_stray = 0, rx_busy = 0, last_no_ack = 0;

  typedef struct {logic [11:0] bits; int len; bit b2b;} tx_exp_t;
  typedef struct {logic [7:0] data; logic pe, fe, oe; bit no_ack;} rx_exp_t;
  tx_exp_t txq[$];
  rx_exp_t rxq[$];

  // Frame format the bench last programmed
  logic m_pi = 1, m_sbs = 0, m_epe = 0;
  logic [1:0] m_wls = 2'b11;

  always #5 clk = ~clk;
  always @(posedge clk) tk <= tk + 2'd1;
  assign rx_clk_en = (tk == 2'd3);
  assign tx_clk_en = (tk == 2'd3);
  assign rx = loop ? tx : rx_drv;

  trs80_uart_core #(.OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx_clk_en(rx_clk_en), .tx_clk_en(tx_clk_en),
    .din(din), .dout(dout), .thrl(thrl), .crl(crl), .pi(pi), .sbs(sbs), .wls(wls),
    .epe(epe), .drr_n(drr_n), .pe(pe), .fe(fe), .oe(oe), .thre(thre), .tre(tre),
    .dr(dr), .rx(rx), .tx(tx)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] keep_bits(input logic [7:0] d);
    logic [7:0] m = '0;
    for (int i = 0; i < int'(m_wls) + 5; i++) m[i] = 1'b1;
    return d & m;
  endfunction

  // Line image of one character: start, data LSB first, parity, stop(s)
  function automatic tx_exp_t frame_of(input logic [7:0] d, input bit b2b);
    tx_exp_t e;
    int k, n, ones;
    n = int'(m_wls) + 5;
    ones = 0;
    e.bits = '1;
    e.b2b = b2b;
    e.bits[0] = 1'b0;
    k = 1;
    for (int i = 0; i < n; i++) begin
      e.bits[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (!m_pi) begin
      e.bits[k] = m_epe ? (ones % 2 == 1) : (ones % 2 == 0);
      k++;
    end
    k += m_sbs ? 2 : 1;
    e.len = k;
    return e;
  endfunction

  task automatic set_cfg(input logic p, input logic s, input logic [1:0] w, input logic e);
    @(negedge clk);
    pi = p; sbs = s; wls = w; epe = e; crl = 1'b1;
    @(negedge clk);
    crl = 1'b0;
    m_pi = p; m_sbs = s; m_wls = w; m_epe = e;
  endtask

  task automatic send_tx(input logic [7:0] d, input bit b2b);
    @(negedge clk);
    din = d; thrl = 1'b1;
    txq.push_back(frame_of(d, b2b));
    @(negedge clk);
    thrl = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit no_ack);
    rx_exp_t r;
    r.data = keep_bits(d);
    r.pe = !m_pi && bad_par;
    r.fe = bad_stop;
    r.oe = last_no_ack;
    r.no_ack = no_ack;
    last_no_ack = no_ack;
    rxq.push_back(r);
  endtask

  task automatic drive_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    tx_exp_t f;
    int n;
    f = frame_of(d, 0);
    n = int'(m_wls) + 5;
    if (bad_par && !m_pi) f.bits[n + 1] = ~f.bits[n + 1];
    if (bad_stop) f.bits[m_pi ? n + 1 : n + 2] = 1'b0;
    for (int i = 0; i < f.len; i++) begin
      rx_drv = f.bits[i];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((tre !== 1'b1 || txq.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle_timeout", n < 4000, 1);
  endtask

  task automatic wait_rx_done();
    int n = 0;
    while ((rxq.size() != 0 || rx_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_done_timeout", n < 5000, 1);
  endtask

  // TX monitor: samples each bit mid-period and compares with the queued line image
  initial begin
    tx_exp_t e;
    logic [11:0] got;
    bit tre_bad;
    int n;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        if (txq.size() == 0) begin
          if (!allow_stray) chk("tx_stray_frame", tx, 1);
          while (tx === 1'b0) @(negedge clk);
        end else begin
          e = txq.pop_front();
          got = '1;
          tre_bad = 0;
          repeat (BIT / 2 - 1) @(negedge clk);
          for (int i = 0; i < e.len; i++) begin
            got[i] = tx;
            if (tre !== 1'b0) tre_bad = 1;
            if (i < e.len - 1) repeat (BIT) @(negedge clk);
          end
          chk("tx_frame", got, e.bits);
          chk("tx_tre_busy", tre_bad, 0);
          if (txq.size() > 0 && txq[0].b2b) begin
            n = 0;
            while (tx !== 1'b0 && n < 40) begin
              @(negedge clk);
              n++;
            end
            chk("tx_b2b_gap", (n >= 28 && n < 40), 1);
          end
        end
      end
    end
  end

  // RX monitor: waits for a load, checks RBR/flags, then acknowledges via drr_n
  initial begin
    rx_exp_t e;
    logic [10:0] prev = '0;
    bit prev_no_ack = 0;
    int n;
    forever begin
      @(negedge clk);
      if (rxq.size() > 0) begin
        rx_busy = 1;
        e = rxq.pop_front();
        n = 0;
        while (!(dr === 1'b1 && (!prev_no_ack || {dout, pe, fe, oe} !== prev)) && n < 3000) begin
          @(negedge clk);
          n++;
        end
        chk("rx_timeout", n < 3000, 1);
        chk("rx_dr", dr, 1);
        chk("rx_dout", dout, e.data);
        chk("rx_pe", pe, e.pe);
        chk("rx_fe", fe, e.fe);
        chk("rx_oe", oe, e.oe);
        prev = {dout, pe, fe, oe};
        prev_no_ack = e.no_ack;
        if (!e.no_ack) begin
          drr_n = 1'b0;
          @(negedge clk);
          drr_n = 1'b1;
          chk("rx_dr_clear", dr, 0);
        end
        rx_busy = 0;
      end
    end
  end

  initial begin
    int n;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_thre", thre, 1);
    chk("rst_tre", tre, 1);
    chk("rst_dr", dr, 0);
    chk("rst_pe", pe, 0);
    chk("rst_fe", fe, 0);
    chk("rst_oe", oe, 0);
    chk("rst_dout", dout, 8'h00);

    // Default 8N1 character and its timing
    send_tx(8'hA5, 0);
    chk("thre_after_thrl", thre, 0);
    n = 0;
    while (thre !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("thre_reload", thre, 1);
    while (tre !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tre_frame_time", (n >= 638 && n <= 648), 1);
    wait_tx_idle();

    // 7E1 loopback, then the same character with a corrupted parity bit
    set_cfg(1'b0, 1'b0, 2'b10, 1'b1);
    loop = 1'b1;
    push_rx(8'h41, 0, 0, 0);
    send_tx(8'h41, 0);
    wait_tx_idle();
    wait_rx_done();
    loop = 1'b0;
    push_rx(8'h41, 1, 0, 0);
    drive_rx(8'h41, 1, 0);
    wait_rx_done();

    // Back-to-back 8N1 frames
    set_cfg(1'b1, 1'b0, 2'b11, 1'b0);
    send_tx(8'h55, 0);
    n = 0;
    while (thre !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_thre_wait", n < 2000, 1);
    send_tx(8'hAA, 1);
    wait_tx_idle();

    // Overrun, acknowledge, overrun cleared on next character
    push_rx(8'h12, 0, 0, 1);
    drive_rx(8'h12, 0, 0);
    wait_rx_done();
    push_rx(8'h34, 0, 0, 0);
    drive_rx(8'h34, 0, 0);
    wait_rx_done();
    push_rx(8'h56, 0, 0, 0);
    drive_rx(8'h56, 0, 0);
    wait_rx_done();

    // Short low glitch must not start a character
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_dr", dr, 0);

    // Framing error
    push_rx(8'h3C, 0, 1, 0);
    drive_rx(8'h3C, 0, 1);
    wait_rx_done();

    // Random formats in loopback
    for (int i = 0; i < 10; i++) begin
      set_cfg(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      d = 8'($urandom);
      loop = 1'b1;
      push_rx(d, 0, 0, 0);
      send_tx(d, 0);
      wait_tx_idle();
      wait_rx_done();
      loop = 1'b0;
    end

    // Random formats with random parity/stop corruption on the receive line
    for (int i = 0; i < 8; i++) begin
      bit bp, bs;
      set_cfg(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      d = 8'($urandom);
      bp = 1'($urandom);
      bs = 1'($urandom);
      push_rx(d, bp, bs, 0);
      drive_rx(d, bp, bs);
      wait_rx_done();
    end

    // Reset in the middle of a transmitted character
    set_cfg(1'b1, 1'b0, 2'b11, 1'b0);
    allow_stray = 1;
    @(negedge clk);
    din = 8'h00;
    thrl = 1'b1;
    @(negedge clk);
    thrl = 1'b0;
    repeat (300) @(negedge clk);
    chk("pre_reset_tx_low", tx, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_thre", thre, 1);
    chk("reset_tre", tre, 1);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
